// File: rtl/wresp_chan_slv_pkg.sv
// -----------------------------------------------------------------------------
// wresp_chan_slv_pkg
//   Shared definitions for the write-response channel blocks.
//   - WRESP_ID_W : default transaction ID width, shared with the master-side
//                  response manager so both ends agree on bid width.
//   - WRESP_SIDLE / WRESP_SRESP : response FSM state encodings.
//   Optional feature macro used by the top: WRESP_TMO_EN.
// -----------------------------------------------------------------------------
package wresp_chan_slv_pkg;

    localparam int WRESP_ID_W = 4;

    typedef logic [0:0] wresp_state_t;

    localparam logic [0:0] WRESP_SIDLE = 1'b0;  // no response presented
    localparam logic [0:0] WRESP_SRESP = 1'b1;  // bvalid asserted

endpackage : wresp_chan_slv_pkg

// File: rtl/wresp_chan_slv_if.sv
// -----------------------------------------------------------------------------
// wresp_chan_slv_if
//   Bundles the write-completion input group and the B channel.
//   Ports of the modports:
//     slave  (responder)  : in  wd_done, wd_id, wd_ok, bready
//                           out bvalid, bid, bcomp
//     master (environment): the mirror image.
//   Handshake: a response transfers on a rising clk edge where bvalid and
//   bready are both 1. Once bvalid is 1 it stays 1, with bid/bcomp stable,
//   until that transfer happens; bready may toggle freely and does not
//   depend on bvalid.
// -----------------------------------------------------------------------------
interface wresp_chan_slv_if
    import wresp_chan_slv_pkg::*;
#(
    parameter int ID_W = WRESP_ID_W
);
    logic            wd_done;
    logic [ID_W-1:0] wd_id;
    logic            wd_ok;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic            bcomp;

    modport slave (
        input  wd_done, wd_id, wd_ok, bready,
        output bvalid, bid, bcomp
    );

    modport master (
        output wd_done, wd_id, wd_ok, bready,
        input  bvalid, bid, bcomp
    );
endinterface : wresp_chan_slv_if

// File: rtl/wresp_chan_slv_fifo.sv
// -----------------------------------------------------------------------------
// wresp_fifo
//   Generic synchronous FIFO, DEPTH entries of W bits, async active-high reset.
//   Ports:
//     clk, rst        clock / asynchronous reset
//     push, push_data write request (ignored while full)
//     pop             read request (ignored while empty)
//     head_data       entry at the read pointer (show-ahead)
//     full, empty     derived from the registered entry count
//     count           registered entry count, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wresp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 5,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a push while full is
    // dropped even if a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : wresp_fifo

// File: rtl/wresp_chan_slv.sv
// -----------------------------------------------------------------------------
// wresp_chan_slv
//   Responder end of the write response (B) channel. Queues {id, ok}
//   completion events from the local write data path and presents them,
//   in completion order, as bvalid/bid/bcomp, one per bready handshake.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     bus          wresp_chan_slv_if.slave: wd_done/wd_id/wd_ok in,
//                  bvalid/bid/bcomp out, bready in
//     wresp_full   pending FIFO full; upstream must hold off wd_done
//     pend_cnt     entries in the FIFO (output register not counted)
//     wresp_ovf    sticky: wd_done arrived while full (event dropped)
//     wresp_tmo    sticky bvalid-stall timeout, 0 unless WRESP_TMO_EN
//     state_dbg    current response FSM state
//   Optional feature macro: WRESP_TMO_EN (stall timeout counter).
//   Capacity is DEPTH+1 responses: DEPTH in the FIFO plus the output register.
// -----------------------------------------------------------------------------
module wresp_chan_slv
    import wresp_chan_slv_pkg::*;
#(
    parameter  int ID_W    = WRESP_ID_W,
    parameter  int DEPTH   = 4,
    parameter  int TMO_CYC = 255,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    wresp_chan_slv_if.slave      bus,
    output logic                 wresp_full,
    output logic [CW-1:0]        pend_cnt,
    output logic                 wresp_ovf,
    output logic                 wresp_tmo,
    output wresp_state_t         state_dbg
);

    logic [0:0]      state_q, state_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic            bcomp_q, bcomp_d;
    logic            ovf_q, ovf_d;

    logic            fifo_pop;
    logic [ID_W:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    wresp_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wd_done),
        .push_data ({bus.wd_id, bus.wd_ok}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Response FSM. The output register is refilled straight from the FIFO
    // head on the handshake edge, so a non-empty FIFO drains with no bubble.
    always_comb begin
        state_d  = state_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bcomp_d  = bcomp_q;
        fifo_pop = 1'b0;
        case (state_q)
            WRESP_SIDLE: begin
                if (!fifo_empty) begin
                    {bid_d, bcomp_d} = fifo_head;
                    fifo_pop         = 1'b1;
                    bvalid_d         = 1'b1;
                    state_d          = WRESP_SRESP;
                end
            end
            WRESP_SRESP: begin
                if (bus.bready) begin
                    if (!fifo_empty) begin
                        {bid_d, bcomp_d} = fifo_head;
                        fifo_pop         = 1'b1;
                    end else begin
                        // bid/bcomp keep their last value; only bvalid drops.
                        bvalid_d = 1'b0;
                        state_d  = WRESP_SIDLE;
                    end
                end
            end
            default: begin
                bvalid_d = 1'b0;
                state_d  = WRESP_SIDLE;
            end
        endcase
    end

    assign ovf_d = ovf_q | (bus.wd_done & fifo_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WRESP_SIDLE;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bcomp_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bcomp_q  <= bcomp_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef WRESP_TMO_EN
    localparam int            TW      = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;

    // Counts stalled cycles of the current response; any handshake or an
    // idle cycle restarts it. Saturates so it can never wrap back to 0.
    always_comb begin
        tmo_cnt_d = '0;
        if (bvalid_q && !bus.bready) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
        end
        tmo_d = tmo_q | (tmo_cnt_d == TMO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign wresp_tmo = tmo_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TMO_CYC == 0);
    assign wresp_tmo      = 1'b0;
`endif

    assign bus.bvalid = bvalid_q;
    assign bus.bid    = bid_q;
    assign bus.bcomp  = bcomp_q;
    assign wresp_full = fifo_full;
    assign pend_cnt   = fifo_count;
    assign wresp_ovf  = ovf_q;
    assign state_dbg  = state_q;

endmodule : wresp_chan_slv

// File: tb/tb_wresp_chan_slv.sv
// -----------------------------------------------------------------------------
// tb_wresp_chan_slv
//   Directed bench for wresp_chan_slv (ID_W=4, DEPTH=4, TMO_CYC=8).
//   Inputs change 1 ns after a rising edge; outputs are sampled at 1 ns
//   after the edge (directed checks) or on the falling edge (monitor).
//   Timeout checks follow WRESP_TMO_EN.
// -----------------------------------------------------------------------------
module tb_wresp_chan_slv;
    import wresp_chan_slv_pkg::*;

    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int TMO_CYC = 8;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          wresp_full;
    logic [CW-1:0] pend_cnt;
    logic          wresp_ovf;
    logic          wresp_tmo;
    wresp_state_t  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [ID_W:0] exp_q[$];   // expected {bid, bcomp} in handshake order

    wresp_chan_slv_if #(.ID_W(ID_W)) bus_if ();

    wresp_chan_slv #(
        .ID_W    (ID_W),
        .DEPTH   (DEPTH),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .wresp_full (wresp_full),
        .pend_cnt   (pend_cnt),
        .wresp_ovf  (wresp_ovf),
        .wresp_tmo  (wresp_tmo),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle wd_done pulse; acc=1 means the event must reach the B channel.
    task automatic wd_pulse(input logic [ID_W-1:0] id, input logic ok, input bit acc);
        bus_if.wd_done = 1'b1;
        bus_if.wd_id   = id;
        bus_if.wd_ok   = ok;
        if (acc) exp_q.push_back({id, ok});
        tick();
        bus_if.wd_done = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && !bus_if.bvalid) break;
            tick();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_bvalid", bus_if.bvalid, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          prev_v;
    logic          prev_rdy;
    logic [ID_W:0] prev_resp;
    logic [ID_W:0] exp_resp;

    initial prev_v = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            // A stalled response must persist unchanged.
            if (prev_v && !prev_rdy) begin
                check("b_hold_valid", bus_if.bvalid, 1);
                check("b_hold_resp", {bus_if.bid, bus_if.bcomp}, prev_resp);
            end
            if (bus_if.bvalid && bus_if.bready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL b_unexpected: observed bid %0h with no expected response", bus_if.bid);
                end else begin
                    exp_resp = exp_q.pop_front();
                    check("b_resp", {bus_if.bid, bus_if.bcomp}, exp_resp);
                end
            end
            prev_v    = bus_if.bvalid;
            prev_rdy  = bus_if.bready;
            prev_resp = {bus_if.bid, bus_if.bcomp};
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst            = 1'b1;
        bus_if.wd_done = 1'b0;
        bus_if.wd_id   = '0;
        bus_if.wd_ok   = 1'b0;
        bus_if.bready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_bvalid", bus_if.bvalid, 0);
        check("rst_bid", bus_if.bid, 0);
        check("rst_bcomp", bus_if.bcomp, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_full", wresp_full, 0);
        check("rst_ovf", wresp_ovf, 0);
        check("rst_tmo", wresp_tmo, 0);
        check("rst_state", state_dbg, WRESP_SIDLE);
        rst = 1'b0;
        repeat (3) tick();

        // Single response: 2-cycle latency, one-cycle bvalid with bready=1
        bus_if.bready = 1'b1;
        wd_pulse(4'd5, 1'b1, 1'b1);
        check("single_lat_bvalid", bus_if.bvalid, 0);
        check("single_lat_pend", pend_cnt, 1);
        tick();
        check("single_bvalid", bus_if.bvalid, 1);
        check("single_bid", bus_if.bid, 5);
        check("single_bcomp", bus_if.bcomp, 1);
        check("single_pend", pend_cnt, 0);
        check("single_state", state_dbg, WRESP_SRESP);
        tick();
        check("single_done_bvalid", bus_if.bvalid, 0);
        check("single_done_state", state_dbg, WRESP_SIDLE);

        // Backpressure: response held through 20 stalled cycles
        bus_if.bready = 1'b0;
        wd_pulse(4'd3, 1'b0, 1'b1);
        tick();
        check("bp_bvalid", bus_if.bvalid, 1);
        check("bp_bid", bus_if.bid, 3);
        check("bp_bcomp", bus_if.bcomp, 0);
        repeat (7) tick();
        check("bp_tmo_7", wresp_tmo, 0);
        tick();
`ifdef WRESP_TMO_EN
        check("bp_tmo_8", wresp_tmo, 1);
`else
        check("bp_tmo_8", wresp_tmo, 0);
`endif
        check("bp_tmo_bvalid", bus_if.bvalid, 1);
        repeat (12) tick();
        check("bp_end_bvalid", bus_if.bvalid, 1);
        check("bp_end_bid", bus_if.bid, 3);
        bus_if.bready = 1'b1;
        tick();
        check("bp_release_bvalid", bus_if.bvalid, 0);
        repeat (2) tick();

        // Burst: ids 1..5 back to back, handshakes with no bubble
        for (int k = 1; k <= 5; k++) begin
            wd_pulse(ID_W'(k), k[0], 1'b1);
            if (k >= 2) begin
                check("burst_bvalid", bus_if.bvalid, 1);
                check("burst_bid", bus_if.bid, k - 1);
            end
        end
        tick();
        check("burst_last_bvalid", bus_if.bvalid, 1);
        check("burst_last_bid", bus_if.bid, 5);
        tick();
        check("burst_end_bvalid", bus_if.bvalid, 0);
        wait_drain(10);

        // Full / overflow: 1 in output reg, 2..5 in FIFO, 6 dropped
        bus_if.bready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wd_pulse(ID_W'(k), 1'b1, 1'b1);
        end
        check("full_flag", wresp_full, 1);
        check("full_pend", pend_cnt, 4);
        check("full_ovf_before", wresp_ovf, 0);
        check("full_bid", bus_if.bid, 1);
        wd_pulse(4'd6, 1'b0, 1'b0);
        check("ovf_flag", wresp_ovf, 1);
        check("ovf_pend", pend_cnt, 4);
        // Push while full with a pop in the same cycle is still dropped
        bus_if.bready = 1'b1;
        wd_pulse(4'd7, 1'b0, 1'b0);
        check("ovf_pop_pend", pend_cnt, 3);
        check("ovf_pop_full", wresp_full, 0);
        check("ovf_pop_bid", bus_if.bid, 2);
        wait_drain(20);
        check("ovf_sticky", wresp_ovf, 1);
        check("ovf_drain_pend", pend_cnt, 0);

        // Push and pop in the same cycle at count=2
        bus_if.bready = 1'b0;
        wd_pulse(4'd8, 1'b0, 1'b1);
        wd_pulse(4'd9, 1'b1, 1'b1);
        wd_pulse(4'd10, 1'b0, 1'b1);
        check("pp_pend_before", pend_cnt, 2);
        check("pp_bid_before", bus_if.bid, 8);
        bus_if.bready = 1'b1;
        wd_pulse(4'd11, 1'b1, 1'b1);
        bus_if.bready = 1'b0;
        check("pp_pend_after", pend_cnt, 2);
        check("pp_bid_after", bus_if.bid, 9);
        tick();
        bus_if.bready = 1'b1;
        wait_drain(20);

        // Reset in the middle of a stalled response
        bus_if.bready = 1'b0;
        wd_pulse(4'd12, 1'b1, 1'b1);
        wd_pulse(4'd13, 1'b0, 1'b1);
        repeat (TMO_CYC + 1) tick();
        check("mid_bvalid", bus_if.bvalid, 1);
        check("mid_bid", bus_if.bid, 12);
`ifdef WRESP_TMO_EN
        check("mid_tmo", wresp_tmo, 1);
`else
        check("mid_tmo", wresp_tmo, 0);
`endif
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_bvalid", bus_if.bvalid, 0);
        check("arst_pend", pend_cnt, 0);
        check("arst_tmo", wresp_tmo, 0);
        check("arst_ovf", wresp_ovf, 0);
        check("arst_state", state_dbg, WRESP_SIDLE);
        tick();
        rst = 1'b0;
        tick();

        // Recovery after reset
        bus_if.bready = 1'b1;
        wd_pulse(4'd14, 1'b1, 1'b1);
        wait_drain(10);
        check("final_pend", pend_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wresp_chan_slv
